clip_memory_sequencer: RTL and testbench

//  Memory-side responder to the playback/record controller: two clip banks of block RAM plus address sequencing.

---
 rtl/clip_memory_sequencer_if.sv | 33 +++
 rtl/clip_memory_sequencer.sv | 117 +++++++++++
 tb/tb_clip_memory_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/clip_memory_sequencer_if.sv
// Controller <-> clip memory bundle: session enables, record/play strobes and the playback word.
// slave = memory side (the sequencer), master = controller / serializer / deserializer side.
interface clip_memory_sequencer_if #(
   parameter int WORD_LENGTH = 16,
   parameter int ADDR_WIDTH  = 12
);
   logic                    memory_rw_i;
   logic                    memory_0_enable_i;
   logic                    memory_1_enable_i;
   logic                    deserializer_done_i;
   logic [WORD_LENGTH-1:0]  deserializer_word_i;
   logic                    serializer_done_i;
   logic [WORD_LENGTH-1:0]  serializer_word_o;
   logic                    serializer_valid_o;
   logic                    timer_done_o;
   logic                    busy_o;
   logic                    underrun_o;
   logic [ADDR_WIDTH:0]     sample_count_o;

   modport slave (
      input  memory_rw_i, memory_0_enable_i, memory_1_enable_i,
      input  deserializer_done_i, deserializer_word_i, serializer_done_i,
      output serializer_word_o, serializer_valid_o, timer_done_o, busy_o,
      output underrun_o, sample_count_o
   );

   modport master (
      output memory_rw_i, memory_0_enable_i, memory_1_enable_i,
      output deserializer_done_i, deserializer_word_i, serializer_done_i,
      input  serializer_word_o, serializer_valid_o, timer_done_o, busy_o,
      input  underrun_o, sample_count_o
   );
endinterface

// File: rtl/clip_memory_sequencer.sv
// Two-bank clip RAM with record/play address sequencing; first play word valid 3 cycles after start.
// No backpressure: record strobes are written on arrival, early serializer strobes are dropped and flagged.
module clip_memory_sequencer #(
   parameter int WORD_LENGTH  = 16,
   parameter int ADDR_WIDTH   = 12,
   parameter int CLIP_SAMPLES = 4096
) (
   input logic                    clock_i,
   input logic                    reset_i,
   clip_memory_sequencer_if.slave bus
);
   localparam logic [ADDR_WIDTH:0] CLIP_COUNT = (ADDR_WIDTH+1)'(CLIP_SAMPLES);

   typedef enum logic [2:0] {
      S_IDLE, S_REC, S_FETCH, S_LOAD, S_READY, S_DONE
   } state_t;

   state_t                  state, state_nxt;
   logic                    bank;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [ADDR_WIDTH:0]     count;
   logic [ADDR_WIDTH:0]     count_next;
   logic [WORD_LENGTH-1:0]  word;
   logic                    valid;
   logic                    underrun;
   logic [WORD_LENGTH-1:0]  rd_data;
   logic [WORD_LENGTH-1:0]  mem0 [2**ADDR_WIDTH];
   logic [WORD_LENGTH-1:0]  mem1 [2**ADDR_WIDTH];

   logic both_hi, both_lo, one_hi, last;
   logic abort, start, wr_en, load, advance, underrun_set, clr_valid;

   assign both_hi    = bus.memory_0_enable_i & bus.memory_1_enable_i;
   assign both_lo    = ~bus.memory_0_enable_i & ~bus.memory_1_enable_i;
   assign one_hi     = bus.memory_0_enable_i ^ bus.memory_1_enable_i;
   assign count_next = count + 1'b1;
   assign last       = (count_next == CLIP_COUNT);

   always_ff @(posedge clock_i) begin
      if (!reset_i) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (both_hi) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (one_hi) state_nxt = bus.memory_rw_i ? S_REC : S_FETCH;
            S_REC:   if (both_lo) state_nxt = S_IDLE;
                     else if (bus.deserializer_done_i && last) state_nxt = S_DONE;
            S_FETCH: state_nxt = both_lo ? S_IDLE : S_LOAD;
            S_LOAD:  state_nxt = both_lo ? S_IDLE : S_READY;
            S_READY: if (both_lo) state_nxt = S_IDLE;
                     else if (bus.serializer_done_i) state_nxt = last ? S_DONE : S_FETCH;
            S_DONE:  if (both_lo) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      abort        = both_hi || (both_lo && state != S_IDLE && state != S_DONE);
      start        = (state == S_IDLE) && one_hi;
      wr_en        = (state == S_REC) && bus.deserializer_done_i && !abort && reset_i;
      load         = (state == S_LOAD) && !abort;
      advance      = wr_en || ((state == S_READY) && bus.serializer_done_i && !abort);
      underrun_set = ((state == S_FETCH) || (state == S_LOAD)) && bus.serializer_done_i;
      // Valid drops while the next word is in flight so a stale word is never consumed twice.
      clr_valid    = abort || ((state == S_READY) && bus.serializer_done_i);
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         bank     <= 1'b0;
         addr     <= '0;
         count    <= '0;
         word     <= '0;
         valid    <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (start) begin
            bank     <= bus.memory_1_enable_i;
            addr     <= '0;
            count    <= '0;
            underrun <= 1'b0;
         end
         if (advance) begin
            addr  <= addr + 1'b1;
            count <= count_next;
         end
         if (underrun_set) underrun <= 1'b1;
         if (load) begin
            word  <= rd_data;
            valid <= 1'b1;
         end
         if (clr_valid) valid <= 1'b0;
      end
   end

   // RAM contents survive reset; the read port samples every cycle and is consumed in LOAD.
   always_ff @(posedge clock_i) begin
      if (wr_en) begin
         if (bank) mem1[addr] <= bus.deserializer_word_i;
         else      mem0[addr] <= bus.deserializer_word_i;
      end
      rd_data <= bank ? mem1[addr] : mem0[addr];
   end

   assign bus.serializer_word_o  = word;
   assign bus.serializer_valid_o = valid;
   assign bus.timer_done_o       = (state == S_DONE);
   assign bus.busy_o             = (state != S_IDLE);
   assign bus.underrun_o         = underrun;
   assign bus.sample_count_o     = count;
endmodule

// File: tb/tb_clip_memory_sequencer.sv
// Directed record/play/abort/underrun/reset sequence against a CLIP_SAMPLES=8, ADDR_WIDTH=3 instance.
module tb_clip_memory_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   clip_memory_sequencer_if #(.WORD_LENGTH(16), .ADDR_WIDTH(3)) bus ();

   clip_memory_sequencer #(
      .WORD_LENGTH(16), .ADDR_WIDTH(3), .CLIP_SAMPLES(8)
   ) dut (
      .clock_i (clk),
      .reset_i (rst_n),
      .bus     (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rec_strobe(input logic [15:0] w);
      bus.deserializer_word_i = w;
      bus.deserializer_done_i = 1'b1;
      tick();
      bus.deserializer_done_i = 1'b0;
   endtask

   task automatic ser_strobe();
      bus.serializer_done_i = 1'b1;
      tick();
      bus.serializer_done_i = 1'b0;
   endtask

   task automatic record_clip(input logic b, input logic [15:0] base);
      bus.memory_rw_i = 1'b1;
      bus.memory_0_enable_i = !b;
      bus.memory_1_enable_i = b;
      tick();
      check("rec_busy", bus.busy_o, 1);
      check("rec_count_start", bus.sample_count_o, 0);
      for (int i = 0; i < 8; i++) begin
         rec_strobe(base + 16'(i));
         if (i < 7) check("rec_timer_early", bus.timer_done_o, 0);
      end
      check("rec_timer_done", bus.timer_done_o, 1);
      check("rec_count_8", bus.sample_count_o, 8);
   endtask

   task automatic stop_session();
      bus.memory_0_enable_i = 1'b0;
      bus.memory_1_enable_i = 1'b0;
      tick();
      check("stop_busy", bus.busy_o, 0);
      check("stop_timer", bus.timer_done_o, 0);
   endtask

   task automatic play_clip(input logic b, input logic [15:0] base);
      bus.memory_rw_i = 1'b0;
      bus.memory_0_enable_i = !b;
      bus.memory_1_enable_i = b;
      tick();
      tick();
      check("play_valid_early", bus.serializer_valid_o, 0);
      tick();
      check("play_valid_first", bus.serializer_valid_o, 1);
      check("play_word_first", bus.serializer_word_o, base);
      for (int i = 1; i < 8; i++) begin
         ser_strobe();
         check("play_count", bus.sample_count_o, i);
         tick();
         tick();
         check("play_word", bus.serializer_word_o, base + 16'(i));
         check("play_valid", bus.serializer_valid_o, 1);
      end
      ser_strobe();
      check("play_timer_done", bus.timer_done_o, 1);
      check("play_valid_end", bus.serializer_valid_o, 0);
      check("play_count_8", bus.sample_count_o, 8);
      stop_session();
   endtask

   initial begin
      bus.memory_rw_i = 1'b0;
      bus.memory_0_enable_i = 1'b0;
      bus.memory_1_enable_i = 1'b0;
      bus.deserializer_done_i = 1'b0;
      bus.deserializer_word_i = '0;
      bus.serializer_done_i = 1'b0;
      tick();
      tick();
      check("rst_busy", bus.busy_o, 0);
      check("rst_timer", bus.timer_done_o, 0);
      check("rst_valid", bus.serializer_valid_o, 0);
      check("rst_word", bus.serializer_word_o, 0);
      check("rst_underrun", bus.underrun_o, 0);
      check("rst_count", bus.sample_count_o, 0);
      rst_n = 1'b1;
      tick();

      // 1: record bank0, then a stray 9th strobe while in DONE
      record_clip(1'b0, 16'hA000);
      rec_strobe(16'hBEEF);
      check("ninth_count", bus.sample_count_o, 8);
      check("ninth_timer", bus.timer_done_o, 1);
      stop_session();

      // 2: play bank0 back (also proves the 9th strobe did not land at addr 0)
      play_clip(1'b0, 16'hA000);

      // 3: bank isolation
      record_clip(1'b1, 16'h5000);
      stop_session();
      play_clip(1'b1, 16'h5000);
      play_clip(1'b0, 16'hA000);

      // 4: abort a record after 3 words, then restart at addr 0
      bus.memory_rw_i = 1'b1;
      bus.memory_1_enable_i = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         rec_strobe(16'hC000 + 16'(i));
         check("abort_timer", bus.timer_done_o, 0);
      end
      stop_session();
      check("abort_count", bus.sample_count_o, 3);
      bus.memory_1_enable_i = 1'b1;
      tick();
      rec_strobe(16'hD000);
      stop_session();
      check("restart_count", bus.sample_count_o, 1);
      bus.memory_rw_i = 1'b0;
      bus.memory_1_enable_i = 1'b1;
      tick();
      tick();
      tick();
      check("restart_word0", bus.serializer_word_o, 16'hD000);
      ser_strobe();
      tick();
      tick();
      check("restart_word1", bus.serializer_word_o, 16'hC001);
      stop_session();

      // 5: underrun in FETCH, then both-enables abort
      bus.memory_0_enable_i = 1'b1;
      tick();
      ser_strobe();
      check("underrun_set", bus.underrun_o, 1);
      check("underrun_count", bus.sample_count_o, 0);
      tick();
      check("underrun_word", bus.serializer_word_o, 16'hA000);
      check("underrun_sticky", bus.underrun_o, 1);
      bus.memory_1_enable_i = 1'b1;
      tick();
      check("both_busy", bus.busy_o, 0);
      check("both_valid", bus.serializer_valid_o, 0);
      check("both_underrun", bus.underrun_o, 1);
      bus.memory_1_enable_i = 1'b0;
      bus.memory_0_enable_i = 1'b0;
      tick();
      bus.memory_rw_i = 1'b1;
      bus.memory_0_enable_i = 1'b1;
      tick();
      bus.memory_1_enable_i = 1'b1;
      rec_strobe(16'hDEAD);
      check("both_rec_busy", bus.busy_o, 0);
      check("both_rec_count", bus.sample_count_o, 0);
      bus.memory_0_enable_i = 1'b0;
      bus.memory_1_enable_i = 1'b0;
      tick();

      // 6: reset mid-play at count 4, then replay from the start
      bus.memory_rw_i = 1'b0;
      bus.memory_0_enable_i = 1'b1;
      tick();
      tick();
      tick();
      check("pre_reset_underrun", bus.underrun_o, 0);
      for (int i = 1; i <= 4; i++) begin
         ser_strobe();
         tick();
         tick();
      end
      check("pre_reset_count", bus.sample_count_o, 4);
      check("pre_reset_word", bus.serializer_word_o, 16'hA004);
      rst_n = 1'b0;
      bus.memory_0_enable_i = 1'b0;
      tick();
      check("mid_rst_busy", bus.busy_o, 0);
      check("mid_rst_valid", bus.serializer_valid_o, 0);
      check("mid_rst_word", bus.serializer_word_o, 0);
      check("mid_rst_count", bus.sample_count_o, 0);
      check("mid_rst_timer", bus.timer_done_o, 0);
      rst_n = 1'b1;
      tick();
      play_clip(1'b0, 16'hA000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
